// File: rtl/key_event_gen.sv
// -----------------------------------------------------------------------------
// key_event_gen
//
// Turns the debounced key level into single-cycle event pulses so that the
// control FSMs never have to time key levels themselves. All timing is counted
// in sys_clk cycles.
//
// Parameters:
//   ACTIVE_LEVEL : key_i level that means "pressed" (keys are pull-down -> 0)
//   LONG_TIME    : cycles from press_o to long_o
//   REPEAT_TIME  : cycles between repeat_o pulses while long-held
//   DBL_TIME     : window after release_o in which a new press is a double-click
//   BITS         : counter width, must hold max(LONG,REPEAT,DBL)_TIME-1
//
// Ports:
//   sys_clk    in   system clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset, released synchronously
//   key_i      in   debounced key level, synchronous to sys_clk
//   press_o    out  1-cycle pulse on a press edge
//   release_o  out  1-cycle pulse on a release edge
//   long_o     out  1-cycle pulse when a hold reaches LONG_TIME
//   repeat_o   out  1-cycle pulse every REPEAT_TIME while long-held
//   click_o    out  1-cycle pulse for a short press not followed by a second one
//   dbl_o      out  1-cycle pulse on the second press of a double-click
//   key_state  out  1 while the key is considered pressed
//
// All outputs are registered: a pulse is high for the one cycle following the
// clock edge on which its cause (edge or terminal count) was sampled.
// -----------------------------------------------------------------------------
module key_event_gen #(
  parameter logic        ACTIVE_LEVEL = 1'b0,
  parameter int unsigned LONG_TIME    = 12000000,
  parameter int unsigned REPEAT_TIME  = 2400000,
  parameter int unsigned DBL_TIME     = 3600000,
  parameter int unsigned BITS         = 24
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_i,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o,
  output logic click_o,
  output logic dbl_o,
  output logic key_state
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS    = 3'd1,
    ST_LONG     = 3'd2,
    ST_WAIT_DBL = 3'd3,
    ST_PRESS2   = 3'd4
  } state_t;

  // Terminal counts: the event fires on the edge that samples count == TIME-1.
  localparam logic [BITS-1:0] LONG_TC   = BITS'(LONG_TIME - 1);
  localparam logic [BITS-1:0] REPEAT_TC = BITS'(REPEAT_TIME - 1);
  localparam logic [BITS-1:0] DBL_TC    = BITS'(DBL_TIME - 1);
  localparam logic [BITS-1:0] CNT_ZERO  = {BITS{1'b0}};
  localparam logic [BITS-1:0] CNT_ONE   = {{(BITS-1){1'b0}}, 1'b1};

  logic            rst_sync_r;
  logic            key_d_r;
  state_t          state_r;
  state_t          state_nxt_s;
  logic [BITS-1:0] count_r;
  logic [BITS-1:0] count_nxt_s;
  logic [BITS-1:0] count_inc_s;

  logic            pressed_s;
  logic            was_pressed_s;
  logic            press_edge_s;
  logic            rel_edge_s;

  logic            press_nxt_s;
  logic            release_nxt_s;
  logic            long_nxt_s;
  logic            repeat_nxt_s;
  logic            click_nxt_s;
  logic            dbl_nxt_s;
  logic            key_state_nxt_s;

  // Internal reset: asserts with sys_rst_n, deasserts on the first edge after
  // sys_rst_n rises, so a key held through reset yields press_o on edge two.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rst_sync_r <= 1'b0;
    end else begin
      rst_sync_r <= 1'b1;
    end
  end

  // Edge detection against the previous sampled level.
  always_comb begin
    pressed_s     = (key_i == ACTIVE_LEVEL);
    was_pressed_s = (key_d_r == ACTIVE_LEVEL);
    press_edge_s  = pressed_s & ~was_pressed_s;
    rel_edge_s    = ~pressed_s & was_pressed_s;
    count_inc_s   = count_r + CNT_ONE;
  end

  // Next-state, counter and event decode. Edges take priority over terminal
  // counts so that a release or second press in the terminal cycle wins.
  always_comb begin
    state_nxt_s   = state_r;
    count_nxt_s   = CNT_ZERO;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    long_nxt_s    = 1'b0;
    repeat_nxt_s  = 1'b0;
    click_nxt_s   = 1'b0;
    dbl_nxt_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (press_edge_s) begin
          state_nxt_s = ST_PRESS;
          press_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_PRESS: begin
        if (rel_edge_s) begin
          state_nxt_s   = ST_WAIT_DBL;
          release_nxt_s = 1'b1;
        end else if (count_r == LONG_TC) begin
          state_nxt_s = ST_LONG;
          long_nxt_s  = 1'b1;
        end else begin
          count_nxt_s = count_inc_s;
        end
      end

      ST_LONG: begin
        // No click after a long press: release goes straight back to idle.
        if (rel_edge_s) begin
          state_nxt_s   = ST_IDLE;
          release_nxt_s = 1'b1;
        end else if (count_r == REPEAT_TC) begin
          repeat_nxt_s = 1'b1;
        end else begin
          count_nxt_s = count_inc_s;
        end
      end

      ST_WAIT_DBL: begin
        if (press_edge_s) begin
          state_nxt_s = ST_PRESS2;
          press_nxt_s = 1'b1;
          dbl_nxt_s   = 1'b1;
        end else if (count_r == DBL_TC) begin
          state_nxt_s = ST_IDLE;
          click_nxt_s = 1'b1;
        end else begin
          count_nxt_s = count_inc_s;
        end
      end

      ST_PRESS2: begin
        if (rel_edge_s) begin
          state_nxt_s   = ST_IDLE;
          release_nxt_s = 1'b1;
        end else if (count_r == LONG_TC) begin
          state_nxt_s = ST_LONG;
          long_nxt_s  = 1'b1;
        end else begin
          count_nxt_s = count_inc_s;
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase

    case (state_nxt_s)
      ST_PRESS, ST_PRESS2, ST_LONG: key_state_nxt_s = 1'b1;
      default:                      key_state_nxt_s = 1'b0;
    endcase
  end

  // State, counter, key history and registered outputs.
  always_ff @(posedge sys_clk or negedge rst_sync_r) begin
    if (!rst_sync_r) begin
      state_r   <= ST_IDLE;
      count_r   <= CNT_ZERO;
      key_d_r   <= ~ACTIVE_LEVEL;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
      repeat_o  <= 1'b0;
      click_o   <= 1'b0;
      dbl_o     <= 1'b0;
      key_state <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      count_r   <= count_nxt_s;
      key_d_r   <= key_i;
      press_o   <= press_nxt_s;
      release_o <= release_nxt_s;
      long_o    <= long_nxt_s;
      repeat_o  <= repeat_nxt_s;
      click_o   <= click_nxt_s;
      dbl_o     <= dbl_nxt_s;
      key_state <= key_state_nxt_s;
    end
  end

  key_event_gen_chk u_chk (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .press_o   (press_o),
    .long_o    (long_o),
    .repeat_o  (repeat_o),
    .click_o   (click_o),
    .dbl_o     (dbl_o)
  );

endmodule

// -----------------------------------------------------------------------------
// key_event_gen_chk
//
// Output invariants of key_event_gen: timer events are mutually exclusive and
// dbl_o only ever accompanies press_o.
//
// Ports: sys_clk, sys_rst_n and the event outputs being watched.
// -----------------------------------------------------------------------------
module key_event_gen_chk (
  input logic sys_clk,
  input logic sys_rst_n,
  input logic press_o,
  input logic long_o,
  input logic repeat_o,
  input logic click_o,
  input logic dbl_o
);

  a_timer_excl : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    $onehot0({click_o, long_o, repeat_o}))
    else $error("key_event_gen: more than one timer event in a cycle");

  a_dbl_with_press : assert property (@(posedge sys_clk) disable iff (!sys_rst_n)
    dbl_o |-> press_o)
    else $error("key_event_gen: dbl_o without press_o");

endmodule
